// File: rtl/puf_measure_ctrl.sv
// puf_measure_ctrl
//   Sequencer for a ring-oscillator PUF. One evaluation produces 8 response
//   bits. Each bit measures one oscillator pair for a programmable window and
//   then compares the two counts.
//
//   Ports
//     clk, rst_n        : clock; asynchronous reset, active HIGH (rst_n=1 resets)
//     start, abort      : begin one evaluation / cancel the running one
//     challenge[7:0]    : [3:0] base select for bank A, [7:4] for bank B
//     window_cycles     : measurement window in clk cycles (0 acts as 1)
//     cnt_a, cnt_b      : oscillator counts from the datapath
//     sel_a, sel_b      : oscillator selects for the pair under test
//     ro_en, cnt_clr,
//     cnt_en            : oscillator enable, counter clear, counter gate
//     busy              : high whenever the FSM is not idle
//     resp_valid        : one-cycle completion pulse
//     response,
//     tie_mask, sat_err : result bits, equal-count flags, saturation flag
//     dbg_state         : current FSM state, for observation only
//
//   Handshake: start is sampled only in IDLE; the rising edge on which the FSM
//   sees start=1 in IDLE is the accept edge, and challenge/window_cycles are
//   captured on that edge. start while busy is ignored. resp_valid is a pulse
//   with no back-pressure; results stay stable until the next accept.
module puf_measure_ctrl #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       challenge,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  output logic [3:0]       sel_a,
  output logic [3:0]       sel_b,
  output logic             ro_en,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             busy,
  output logic             resp_valid,
  output logic [7:0]       response,
  output logic [7:0]       tie_mask,
  output logic             sat_err,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_MEASURE = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [WIN_W-1:0] SETTLE_LEN = WIN_W'(4);

  state_t           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [7:0]       chal_q, chal_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] cyc_q, cyc_d;
  logic [7:0]       response_q, response_d;
  logic [7:0]       tie_q, tie_d;
  logic             sat_q, sat_d;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      chal_q     <= '0;
      win_q      <= '0;
      cyc_q      <= '0;
      response_q <= '0;
      tie_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      chal_q     <= chal_d;
      win_q      <= win_d;
      cyc_q      <= cyc_d;
      response_q <= response_d;
      tie_q      <= tie_d;
      sat_q      <= sat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    chal_d     = chal_q;
    win_d      = win_q;
    cyc_d      = cyc_q;
    response_d = response_q;
    tie_d      = tie_q;
    sat_d      = sat_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          chal_d  = challenge;
          // A zero window still measures for one cycle.
          win_d   = (window_cycles == '0) ? WIN_W'(1) : window_cycles;
          k_d     = '0;
          tie_d   = '0;
          sat_d   = 1'b0;
        end
      end
      S_SETUP: begin
        state_d = S_MEASURE;
        cyc_d   = WIN_W'(1);
      end
      S_MEASURE: begin
        if (cyc_q >= win_q) begin
          state_d = S_SETTLE;
          cyc_d   = WIN_W'(1);
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
        end
      end
      S_SETTLE: begin
        if (cyc_q == SETTLE_LEN) begin
          state_d = S_COMPARE;
        end else begin
          cyc_d = cyc_q + WIN_W'(1);
        end
      end
      S_COMPARE: begin
        response_d[k_q] = (cnt_a > cnt_b);
        if (cnt_a == cnt_b) tie_d[k_q] = 1'b1;
        if ((cnt_a == {CNT_W{1'b1}}) || (cnt_b == {CNT_W{1'b1}})) sat_d = 1'b1;
        if (k_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SETUP;
          k_d     = k_q + 3'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any other transition; accumulated results are kept.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end
  end

  // Control outputs are pure decodes of the state register.
  assign ro_en      = (state_q == S_SETUP) || (state_q == S_MEASURE);
  assign cnt_clr    = (state_q == S_SETUP);
  assign cnt_en     = (state_q == S_MEASURE);
  assign busy       = (state_q != S_IDLE);
  assign resp_valid = (state_q == S_DONE);

  // Pair k uses base+k in each bank, wrapping mod 16.
  assign sel_a = chal_q[3:0] + {1'b0, k_q};
  assign sel_b = chal_q[7:4] + {1'b0, k_q};

  assign response  = response_q;
  assign tie_mask  = tie_q;
  assign sat_err   = sat_q;
  assign dbg_state = state_q;

endmodule

// File: doc/puf_measure_ctrl.md
PUF_MEASURE_CTRL -- requirements
Module: puf_measure_ctrl

Interface
REQ-001 SHALL have parameter WIN_W, default 16, width of the measurement-window count.
REQ-002 SHALL have parameter CNT_W, default 16, width of each oscillator count returned by the datapath.
REQ-003 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1, request one 8-bit challenge-response evaluation.
REQ-006 SHALL have port abort, input, 1, cancel the evaluation in progress.
REQ-007 SHALL have port challenge, input, 8, captured on the start-accept edge; [3:0] base select A, [7:4] base select B.
REQ-008 SHALL have port window_cycles, input, WIN_W, measurement window length in clk cycles; captured on the start-accept edge.
REQ-009 SHALL have port cnt_a, input, CNT_W, count from oscillator-bank A; stable whenever cnt_en is low.
REQ-010 SHALL have port cnt_b, input, CNT_W, count from oscillator-bank B; same stability rule.
REQ-011 SHALL have port sel_a, output, 4, oscillator select for bank A.
REQ-012 SHALL have port sel_b, output, 4, oscillator select for bank B.
REQ-013 SHALL have port ro_en, output, 1, oscillator enable.
REQ-014 SHALL have port cnt_clr, output, 1, synchronous clear for both counters.
REQ-015 SHALL have port cnt_en, output, 1, counter gate.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-017 SHALL have port resp_valid, output, 1, single-cycle completion pulse.
REQ-018 SHALL have port response, output, 8, response bits, bit k from pair k.
REQ-019 SHALL have port tie_mask, output, 8, bit k set when pair k counts were equal.
REQ-020 SHALL have port sat_err, output, 1, set when any sampled count equalled all-ones.

Function
REQ-021 SHALL implement FSM states IDLE, SETUP, MEASURE, SETTLE, COMPARE, DONE.
REQ-022 IDLE: start=1 SHALL be accepted on that edge, with challenge and window_cycles captured, bit index k=0, tie_mask and sat_err cleared, and transition to SETUP.
REQ-023 SETUP: 1 cycle; cnt_clr=1, ro_en=1; next MEASURE.
REQ-024 MEASURE: exactly W cycles with cnt_en=1, ro_en=1, where W=window_cycles and W=0 is treated as 1; next SETTLE.
REQ-025 SETTLE: exactly 4 cycles; cnt_en=0, ro_en=0; next COMPARE.
REQ-026 COMPARE: 1 cycle; response[k] SHALL equal 1 when cnt_a>cnt_b (unsigned) and 0 otherwise.
REQ-027 COMPARE SHALL set tie_mask[k] when cnt_a==cnt_b, and SHALL set sat_err when either count equals all-ones.
REQ-028 COMPARE SHALL go to SETUP with k+1 when k<7, else to DONE.
REQ-029 DONE: 1 cycle; resp_valid=1; next IDLE.
REQ-030 sel_a SHALL equal (challenge[3:0]+k) mod 16 and sel_b (challenge[7:4]+k) mod 16, held constant from SETUP through COMPARE of bit k.
REQ-031 Per-bit cost SHALL be W+6 cycles; resp_valid SHALL be high in cycle 8(W+6) after the accept edge.
REQ-032 response, tie_mask and sat_err SHALL hold their values from DONE until the next start is accepted.
REQ-033 start SHALL be ignored while busy=1.
REQ-034 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge with ro_en, cnt_en and cnt_clr low, and no resp_valid.
REQ-035 After abort, response SHALL retain its partial bits, and tie_mask and sat_err their partial values.
REQ-036 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL cause the start to be accepted.
REQ-037 sel_a==sel_b SHALL NOT be special-cased; the pair is measured normally.
REQ-038 ro_en, cnt_en, cnt_clr, resp_valid and busy SHALL be driven from registered state only.

Reset
REQ-039 rst_n=1 SHALL immediately force IDLE, k=0, and sel_a, sel_b, ro_en, cnt_clr, cnt_en, busy, resp_valid, response, tie_mask and sat_err all to 0.
REQ-040 Reset mid-evaluation SHALL discard the evaluation; after release, operation SHALL resume only on a new start.

Verification
REQ-041 Run W=10, challenge=8'h21, cnt_a=500, cnt_b=400 for all bits -> resp_valid in cycle 128, response=8'hFF, tie_mask=0, sat_err=0; bit 3 selects sel_a=4, sel_b=5.
REQ-042 Run W=0, cnt_a=cnt_b=7 -> MEASURE lasts 1 cycle, resp_valid in cycle 56, response=8'h00, tie_mask=8'hFF.
REQ-043 Run challenge=8'hF0 -> bit 1 sel_a=1, sel_b=0 (wrap); cnt_b=16'hFFFF on bit 5 -> sat_err=1, response[5]=0.
REQ-044 Assert abort during MEASURE of bit 2 -> next cycle IDLE, busy=0, ro_en=0, no resp_valid, response[1:0] retained.
REQ-045 Assert start while busy -> ignored, captured challenge unchanged; start and abort together in IDLE -> accepted.
REQ-046 Assert rst_n=1 mid-SETTLE -> all outputs 0 without a clock edge; release then start -> full evaluation completes normally.
